// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use hazard detection for the pipelined MIPS core.
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_RD1,
    input  logic [WIDTH-1:0] d_RD2,
    input  logic [WIDTH-1:0] d_SignImm,
    input  logic [4:0]       d_Shamt,
    input  logic [RADDR-1:0] d_Rs,
    input  logic [RADDR-1:0] d_Rt,
    input  logic [RADDR-1:0] d_WriteReg,
    input  logic [2:0]       d_c_ALUControl,
    input  logic             d_c_ALUSrc,
    input  logic             d_c_ShiftSrc,
    input  logic             d_c_RegWrite,
    input  logic             d_c_MemWrite,
    input  logic             d_c_MemtoReg,
    input  logic             m_RegWrite,
    input  logic [RADDR-1:0] m_WriteReg,
    input  logic [WIDTH-1:0] m_ALUResult,
    input  logic             w_RegWrite,
    input  logic [RADDR-1:0] w_WriteReg,
    input  logic [WIDTH-1:0] w_Result,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       c_ALUControl,
    output logic [WIDTH-1:0] e_WriteData,
    output logic [RADDR-1:0] e_WriteReg,
    output logic             e_c_RegWrite,
    output logic             e_c_MemWrite,
    output logic             e_c_MemtoReg,
    output logic             e_valid,
    output logic             LoadUseHazard
);

    logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;
    logic [4:0]       shamt_q;
    logic [RADDR-1:0] rs_q, rt_q, wr_q;
    logic [2:0]       alu_q;
    logic             alusrc_q, shiftsrc_q, regwrite_q, memwrite_q, memtoreg_q, valid_q;

    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wr_q       <= '0;
            alu_q      <= '0;
            alusrc_q   <= 1'b0;
            shiftsrc_q <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (!Stall) begin
            rd1_q      <= d_RD1;
            rd2_q      <= d_RD2;
            imm_q      <= d_SignImm;
            shamt_q    <= d_Shamt;
            rs_q       <= d_Rs;
            rt_q       <= d_Rt;
            wr_q       <= d_WriteReg;
            alu_q      <= d_c_ALUControl;
            alusrc_q   <= d_c_ALUSrc;
            shiftsrc_q <= d_c_ShiftSrc;
            regwrite_q <= d_c_RegWrite;
            memwrite_q <= d_c_MemWrite;
            memtoreg_q <= d_c_MemtoReg;
            valid_q    <= d_valid;
        end
    end

    logic [WIDTH-1:0] fwd_a, fwd_b;

    // Forwarding acts on raw registered RD values, so it tracks later stages even while stalled.
    always_comb begin
        fwd_a = rd1_q;
        if (m_RegWrite && (m_WriteReg == rs_q) && (rs_q != '0))
            fwd_a = m_ALUResult;
        else if (w_RegWrite && (w_WriteReg == rs_q) && (rs_q != '0))
            fwd_a = w_Result;

        fwd_b = rd2_q;
        if (m_RegWrite && (m_WriteReg == rt_q) && (rt_q != '0))
            fwd_b = m_ALUResult;
        else if (w_RegWrite && (w_WriteReg == rt_q) && (rt_q != '0))
            fwd_b = w_Result;
    end

    always_comb begin
        SrcA          = shiftsrc_q ? {{(WIDTH-5){1'b0}}, shamt_q} : fwd_a;
        SrcB          = alusrc_q ? imm_q : fwd_b;
        e_WriteData   = fwd_b;
        c_ALUControl  = alu_q;
        e_WriteReg    = wr_q;
        e_c_RegWrite  = regwrite_q;
        e_c_MemWrite  = memwrite_q;
        e_c_MemtoReg  = memtoreg_q;
        e_valid       = valid_q;
        LoadUseHazard = valid_q && memtoreg_q && (wr_q != '0) &&
                        d_valid && ((d_Rs == wr_q) || (d_Rt == wr_q));
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized bench for id_ex_operand_stage against a
// record-based reference of the ID/EX stage and its forwarding rules.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, Stall, Flush, d_valid;
    logic [31:0] d_RD1, d_RD2, d_SignImm;
    logic [4:0]  d_Shamt, d_Rs, d_Rt, d_WriteReg;
    logic [2:0]  d_c_ALUControl;
    logic        d_c_ALUSrc, d_c_ShiftSrc, d_c_RegWrite, d_c_MemWrite, d_c_MemtoReg;
    logic        m_RegWrite, w_RegWrite;
    logic [4:0]  m_WriteReg, w_WriteReg;
    logic [31:0] m_ALUResult, w_Result;
    logic [31:0] SrcA, SrcB, e_WriteData;
    logic [2:0]  c_ALUControl;
    logic [4:0]  e_WriteReg;
    logic        e_c_RegWrite, e_c_MemWrite, e_c_MemtoReg, e_valid, LoadUseHazard;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .d_valid(d_valid),
        .d_RD1(d_RD1), .d_RD2(d_RD2), .d_SignImm(d_SignImm), .d_Shamt(d_Shamt),
        .d_Rs(d_Rs), .d_Rt(d_Rt), .d_WriteReg(d_WriteReg),
        .d_c_ALUControl(d_c_ALUControl), .d_c_ALUSrc(d_c_ALUSrc),
        .d_c_ShiftSrc(d_c_ShiftSrc), .d_c_RegWrite(d_c_RegWrite),
        .d_c_MemWrite(d_c_MemWrite), .d_c_MemtoReg(d_c_MemtoReg),
        .m_RegWrite(m_RegWrite), .m_WriteReg(m_WriteReg), .m_ALUResult(m_ALUResult),
        .w_RegWrite(w_RegWrite), .w_WriteReg(w_WriteReg), .w_Result(w_Result),
        .SrcA(SrcA), .SrcB(SrcB), .c_ALUControl(c_ALUControl),
        .e_WriteData(e_WriteData), .e_WriteReg(e_WriteReg),
        .e_c_RegWrite(e_c_RegWrite), .e_c_MemWrite(e_c_MemWrite),
        .e_c_MemtoReg(e_c_MemtoReg), .e_valid(e_valid), .LoadUseHazard(LoadUseHazard)
    );

    // Instruction currently held in EX, as the reference sees it.
    typedef struct packed {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  shamt, rs, rt, wr;
        logic [2:0]  alu;
        logic        alusrc, shiftsrc, regw, memw, memtoreg, valid;
    } instr_t;
    instr_t ex = '0;

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval);
        if (r == 0) return regval;
        if (m_RegWrite && m_WriteReg == r) return m_ALUResult;
        if (w_RegWrite && w_WriteReg == r) return w_Result;
        return regval;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] a, b;
        logic        haz;
        a   = ex.shiftsrc ? 32'(ex.shamt) : operand(ex.rs, ex.rd1);
        b   = ex.alusrc ? ex.imm : operand(ex.rt, ex.rd2);
        haz = ex.valid && ex.memtoreg && ex.wr != 0 && d_valid &&
              (d_Rs == ex.wr || d_Rt == ex.wr);
        chk("SrcA", SrcA, a);
        chk("SrcB", SrcB, b);
        chk("e_WriteData", e_WriteData, operand(ex.rt, ex.rd2));
        chk("c_ALUControl", 32'(c_ALUControl), 32'(ex.alu));
        chk("e_WriteReg", 32'(e_WriteReg), 32'(ex.wr));
        chk("e_ctrl", {28'd0, e_c_RegWrite, e_c_MemWrite, e_c_MemtoReg, e_valid},
            {28'd0, ex.regw, ex.memw, ex.memtoreg, ex.valid});
        chk("LoadUseHazard", 32'(LoadUseHazard), 32'(haz));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset || Flush) ex = '0;
        else if (!Stall)
            ex = '{d_RD1, d_RD2, d_SignImm, d_Shamt, d_Rs, d_Rt, d_WriteReg, d_c_ALUControl,
                   d_c_ALUSrc, d_c_ShiftSrc, d_c_RegWrite, d_c_MemWrite, d_c_MemtoReg, d_valid};
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        {d_valid, d_c_ALUSrc, d_c_ShiftSrc, d_c_RegWrite, d_c_MemWrite, d_c_MemtoReg} = '0;
        {d_RD1, d_RD2, d_SignImm} = '0;
        {d_Shamt, d_Rs, d_Rt, d_WriteReg} = '0;
        d_c_ALUControl = '0;
        {m_RegWrite, w_RegWrite} = '0;
        {m_WriteReg, w_WriteReg} = '0;
        {m_ALUResult, w_Result} = '0;
    endtask

    task automatic randomize_d();
        d_valid        = 1'($urandom);
        d_RD1          = $urandom;
        d_RD2          = $urandom;
        d_SignImm      = $urandom;
        d_Shamt        = 5'($urandom);
        d_Rs           = 5'($urandom_range(0, 7));
        d_Rt           = 5'($urandom_range(0, 7));
        d_WriteReg     = 5'($urandom_range(0, 7));
        d_c_ALUControl = 3'($urandom);
        {d_c_ALUSrc, d_c_ShiftSrc, d_c_RegWrite, d_c_MemWrite, d_c_MemtoReg} = 5'($urandom);
    endtask

    initial begin
        idle_inputs();
        {reset, Stall, Flush} = 3'b100;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_SrcA", SrcA, 32'h0);
        chk("reset_SrcB", SrcB, 32'h0);
        chk("reset_valid", 32'(e_valid), 32'h0);
        chk("reset_haz", 32'(LoadUseHazard), 32'h0);

        // add r?, r3, r4
        d_valid = 1; d_Rs = 3; d_Rt = 4; d_WriteReg = 5; d_RD1 = 32'h10; d_RD2 = 32'h20;
        d_c_ALUControl = 3'b010; d_c_RegWrite = 1;
        tick();
        chk("add_SrcA", SrcA, 32'h10);
        chk("add_SrcB", SrcB, 32'h20);
        chk("add_alu", 32'(c_ALUControl), 32'h2);
        chk("add_valid", 32'(e_valid), 32'h1);

        m_RegWrite = 1; m_WriteReg = 3; m_ALUResult = 32'hAA;
        w_RegWrite = 1; w_WriteReg = 3; w_Result = 32'hBB;
        #1; check_all();
        chk("fwd_mem_wins", SrcA, 32'hAA);
        m_RegWrite = 0;
        #1; check_all();
        chk("fwd_wb", SrcA, 32'hBB);
        m_RegWrite = 1; m_WriteReg = 0; w_WriteReg = 0; d_Rs = 0;
        tick();
        chk("fwd_r0_blocked", SrcA, 32'h10);
        idle_inputs();

        // sll
        d_valid = 1; d_c_ShiftSrc = 1; d_Shamt = 5; d_Rt = 2; d_RD2 = 32'h3; d_RD1 = 32'hDEAD;
        d_c_ALUControl = 3'b100; d_c_RegWrite = 1; d_WriteReg = 9;
        tick();
        chk("sll_SrcA", SrcA, 32'h5);
        chk("sll_SrcB", SrcB, 32'h3);
        chk("sll_alu", 32'(c_ALUControl), 32'h4);
        idle_inputs();

        // sw
        d_valid = 1; d_c_ALUSrc = 1; d_SignImm = 32'hFFFF_FFFC; d_Rt = 6; d_RD2 = 32'h55;
        d_c_MemWrite = 1; d_c_ALUControl = 3'b010;
        tick();
        chk("sw_SrcB", SrcB, 32'hFFFF_FFFC);
        chk("sw_WriteData", e_WriteData, 32'h55);
        idle_inputs();

        // lw r7 then a dependent instruction in ID
        d_valid = 1; d_c_MemtoReg = 1; d_c_RegWrite = 1; d_WriteReg = 7; d_c_ALUSrc = 1;
        tick();
        d_c_MemtoReg = 0; d_WriteReg = 8; d_Rs = 1; d_Rt = 7;
        #1; check_all();
        chk("lu_hazard", 32'(LoadUseHazard), 32'h1);
        Flush = 1;
        tick();
        Flush = 0;
        chk("lu_bubble_valid", 32'(e_valid), 32'h0);
        chk("lu_bubble_regw", 32'(e_c_RegWrite), 32'h0);
        chk("lu_bubble_haz", 32'(LoadUseHazard), 32'h0);

        // Stall holds; forwarding still tracks later stages
        d_Rs = 2; d_Rt = 3; d_RD1 = 32'h111; d_RD2 = 32'h222; d_WriteReg = 4;
        d_c_MemtoReg = 0; d_c_ALUSrc = 0;
        tick();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_d();
            tick();
            chk("stall_SrcA", SrcA, 32'h111);
        end
        m_RegWrite = 1; m_WriteReg = 2; m_ALUResult = 32'h999;
        #1; check_all();
        chk("stall_fwd", SrcA, 32'h999);
        Flush = 1;
        tick();
        chk("stall_flush", 32'(e_valid), 32'h0);
        Flush = 0;
        Stall = 0;
        d_valid = 1;
        tick();
        Stall = 1; reset = 1;
        tick();
        chk("stall_reset", 32'(e_valid), 32'h0);
        {reset, Stall} = '0;

        for (int i = 0; i < 400; i++) begin
            randomize_d();
            reset       = ($urandom_range(0, 49) == 0);
            Flush       = ($urandom_range(0, 9) == 0);
            Stall       = ($urandom_range(0, 4) == 0);
            m_RegWrite  = 1'($urandom);
            w_RegWrite  = 1'($urandom);
            m_WriteReg  = 5'($urandom_range(0, 7));
            w_WriteReg  = 5'($urandom_range(0, 7));
            m_ALUResult = $urandom;
            w_Result    = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding muxes for the pipelined MIPS core.
- Latches decoded operands and control in ID, then drives the ALU's SrcA, SrcB and c_ALUControl in EX.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Flags load-use hazards so the hazard unit can stall the front end.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-specifier width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Stall  in  1  hold ID/EX contents.
- Flush  in  1  load a bubble into ID/EX.
- d_valid  in  1  ID holds a real instruction.
- d_RD1, d_RD2  in  WIDTH each  register-file read data.
- d_SignImm  in  WIDTH  sign-extended immediate.
- d_Shamt  in  5  instr[10:6].
- d_Rs, d_Rt, d_WriteReg  in  RADDR each  source and destination specifiers.
- d_c_ALUControl  in  3  ALU op code.
- d_c_ALUSrc, d_c_ShiftSrc, d_c_RegWrite, d_c_MemWrite, d_c_MemtoReg  in  1 each  decoded control.
- m_RegWrite / m_WriteReg / m_ALUResult  in  1 / RADDR / WIDTH  EX/MEM forwarding source.
- w_RegWrite / w_WriteReg / w_Result  in  1 / RADDR / WIDTH  MEM/WB forwarding source.
- SrcA, SrcB  out  WIDTH  ALU operands.
- c_ALUControl  out  3  registered ALU op.
- e_WriteData  out  WIDTH  forwarded rt value, used as store data.
- e_WriteReg  out  RADDR  registered destination.
- e_c_RegWrite, e_c_MemWrite, e_c_MemtoReg  out  1 each  registered control.
- e_valid  out  1  EX holds a real instruction.
- LoadUseHazard  out  1  combinational stall request.

Behaviour:
- Registered fields: RD1, RD2, SignImm, Shamt, Rs, Rt, WriteReg, ALUControl, ALUSrc, ShiftSrc, RegWrite, MemWrite, MemtoReg, valid.
- Edge priority, highest first: reset > Flush > Stall > load.
- reset or Flush: every registered field cleared to 0. A bubble therefore has valid=0, RegWrite=0, MemWrite=0 and ALUControl=000.
- Stall (without Flush): all fields hold.
- Otherwise: all fields load from the d_ inputs.
- Latency: ID values appear on the outputs one cycle after the loading edge.
- Forwarding, combinational on the registered Rs (fwdA) and applied identically to Rt (fwdB):
  - If m_RegWrite and m_WriteReg==Rs and Rs!=0, select m_ALUResult.
  - Else if w_RegWrite and w_WriteReg==Rs and Rs!=0, select w_Result.
  - Else select registered RD1 (RD2 for fwdB).
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- SrcA = ShiftSrc ? zero-extended registered Shamt (bits 31:5 = 0) : fwdA. The ALU shift takes its amount from SrcA[4:0].
- SrcB = ALUSrc ? registered SignImm : fwdB.
- e_WriteData = fwdB, independent of ALUSrc.
- c_ALUControl and the e_c_* outputs are driven directly from their registers.
- LoadUseHazard = e_valid & e_c_MemtoReg & (e_WriteReg!=0) & (d_valid & (d_Rs==e_WriteReg | d_Rt==e_WriteReg)).
  - The hazard unit answers by asserting Stall on IF/ID and Flush on this block in the same cycle.
- After reset, all outputs are 0, including SrcA and SrcB: Rs=Rt=0 blocks forwarding, and ShiftSrc=ALUSrc=0.
- Reset asserted mid-stall discards the held instruction.
- Flush and Stall asserted together yield a bubble.
- Forwarding data may change during a Stall; SrcA and SrcB follow it combinationally, because the registers hold only raw RD values.
- No X on any output after the first reset edge.

Test Plan:
1. Reset then idle -> SrcA=SrcB=0, c_ALUControl=000, e_valid=0, all e_c_*=0, LoadUseHazard=0.
2. Load add with Rs=3, Rt=4, RD1=0x10, RD2=0x20, no forwarding -> next cycle SrcA=0x10, SrcB=0x20, c_ALUControl=010, e_valid=1.
3. Same add with m_RegWrite=1, m_WriteReg=3, m_ALUResult=0xAA, and w_RegWrite=1, w_WriteReg=3, w_Result=0xBB -> SrcA=0xAA. Drop m_RegWrite -> SrcA=0xBB. Change Rs to 0 with both forwards matching 0 -> SrcA=RD1.
4. sll with ShiftSrc=1, Shamt=5, Rt=2, RD2=0x3 -> SrcA=0x00000005, SrcB=0x3, c_ALUControl=100. sw with ALUSrc=1, SignImm=0xFFFFFFFC, RD2=0x55 -> SrcB=0xFFFFFFFC, e_WriteData=0x55.
5. lw in EX with e_WriteReg=7, ID instruction with d_Rt=7 -> LoadUseHazard=1. Assert Flush -> next cycle e_valid=0, e_c_RegWrite=0, LoadUseHazard=0.
6. Hold Stall=1 for 3 cycles with changing d_ inputs -> outputs unchanged. Stall=1 with Flush=1 -> bubble. reset during Stall -> all-zero outputs next cycle.
